// File: rtl/reaction_timer_ctrl.sv
// reaction_timer_ctrl: waits a pseudo-random delay, lights the stimulus LED, and measures the reaction time in ms.
module reaction_timer_ctrl #(
    parameter int          CLK_PER_MS   = 100000,
    parameter int          MIN_DELAY_MS = 2000,
    parameter int          DELAY_BITS   = 12,
    parameter int          MAX_MS       = 9999,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_START_TICK,
    input  logic        i_STOP_TICK,
    input  logic        i_CLEAR_TICK,
    output logic        o_STIM_LED,
    output logic [13:0] o_TIME_MS,
    output logic        o_VALID,
    output logic        o_EARLY,
    output logic        o_TIMEOUT,
    output logic [2:0]  o_STATE
);
    localparam int SUM_W = (DELAY_BITS + 1 > 14) ? DELAY_BITS + 1 : 14;
    localparam int PW = $clog2(CLK_PER_MS + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_RAND = 3'd1,
        MEASURE   = 3'd2,
        DONE      = 3'd3,
        EARLY     = 3'd4
    } state_t;

    state_t           state;
    logic [15:0]      lfsr;
    logic [PW-1:0]    presc;
    logic [13:0]      elapsed_ms;
    logic [13:0]      reaction_ms;
    logic [SUM_W-1:0] delay_ms;
    logic             ms_tick;

    if (MIN_DELAY_MS + 2 ** DELAY_BITS - 1 > 16383) begin : g_bad_delay
        $error("MIN_DELAY_MS + 2^DELAY_BITS - 1 exceeds 16383");
    end
    if (LFSR_SEED == 16'h0) begin : g_bad_seed
        $error("LFSR_SEED must be nonzero");
    end

    assign ms_tick = presc == PW'(CLK_PER_MS - 1);
    assign o_STATE = state;

    always_ff @(posedge i_CLK) begin
        lfsr <= i_RST ? LFSR_SEED : ({1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000));
        if (i_RST || i_CLEAR_TICK) begin
            state       <= IDLE;
            presc       <= '0;
            elapsed_ms  <= '0;
            reaction_ms <= '0;
            delay_ms    <= '0;
            o_STIM_LED  <= 1'b0;
            o_TIME_MS   <= '0;
            o_VALID     <= 1'b0;
            o_EARLY     <= 1'b0;
            o_TIMEOUT   <= 1'b0;
        end else begin
            presc <= ms_tick ? '0 : presc + 1'b1;
            case (state)
                IDLE: begin
                    if (i_START_TICK) begin
                        delay_ms   <= SUM_W'(MIN_DELAY_MS) + SUM_W'(lfsr[DELAY_BITS-1:0]);
                        elapsed_ms <= '0;
                        presc      <= '0;
                        state      <= WAIT_RAND;
                    end
                end
                WAIT_RAND: begin
                    if (i_STOP_TICK) begin
                        state     <= EARLY;
                        o_EARLY   <= 1'b1;
                        o_TIME_MS <= '0;
                    end else if (ms_tick) begin
                        elapsed_ms <= elapsed_ms + 14'd1;
                        if (SUM_W'(elapsed_ms) + SUM_W'(1) == delay_ms) begin
                            state       <= MEASURE;
                            reaction_ms <= '0;
                            presc       <= '0;
                            o_STIM_LED  <= 1'b1;
                        end
                    end
                end
                MEASURE: begin
                    if (i_STOP_TICK) begin
                        state      <= DONE;
                        o_TIME_MS  <= reaction_ms;
                        o_VALID    <= 1'b1;
                        o_STIM_LED <= 1'b0;
                    end else if (ms_tick) begin
                        reaction_ms <= reaction_ms + 14'd1;
                        if (reaction_ms + 14'd1 == 14'(MAX_MS)) begin
                            state      <= DONE;
                            o_TIME_MS  <= 14'(MAX_MS);
                            o_TIMEOUT  <= 1'b1;
                            o_VALID    <= 1'b1;
                            o_STIM_LED <= 1'b0;
                        end
                    end
                end
                DONE: state <= DONE;
                EARLY: state <= EARLY;
                default: begin
                    state      <= IDLE;
                    o_STIM_LED <= 1'b0;
                    o_TIME_MS  <= '0;
                    o_VALID    <= 1'b0;
                    o_EARLY    <= 1'b0;
                    o_TIMEOUT  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// tb_reaction_timer_ctrl: scoreboard bench comparing output transitions against a timing model of the reaction timer.
module tb_reaction_timer_ctrl;
    localparam int CPM = 4;
    localparam int MIN_D = 3;
    localparam int DB = 2;
    localparam int MAXMS = 20;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct packed {
        logic [2:0]  st;
        logic        led;
        logic [13:0] tm;
        logic        valid;
        logic        early;
        logic        tmo;
    } out_t;

    typedef struct packed {
        int   cyc;
        out_t o;
    } ev_t;

    logic        i_CLK = 1'b0;
    logic        i_RST = 1'b1;
    logic        i_START_TICK = 1'b0;
    logic        i_STOP_TICK = 1'b0;
    logic        i_CLEAR_TICK = 1'b0;
    logic        o_STIM_LED;
    logic [13:0] o_TIME_MS;
    logic        o_VALID;
    logic        o_EARLY;
    logic        o_TIMEOUT;
    logic [2:0]  o_STATE;

    ev_t  exp_q[$];
    ev_t  mon_e;
    out_t cur;
    out_t prev;
    out_t idle_o;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rst_edge = 0;
    bit   mon_en = 1'b0;

    reaction_timer_ctrl #(
        .CLK_PER_MS(CPM),
        .MIN_DELAY_MS(MIN_D),
        .DELAY_BITS(DB),
        .MAX_MS(MAXMS),
        .LFSR_SEED(SEED)
    ) dut (
        .i_CLK(i_CLK),
        .i_RST(i_RST),
        .i_START_TICK(i_START_TICK),
        .i_STOP_TICK(i_STOP_TICK),
        .i_CLEAR_TICK(i_CLEAR_TICK),
        .o_STIM_LED(o_STIM_LED),
        .o_TIME_MS(o_TIME_MS),
        .o_VALID(o_VALID),
        .o_EARLY(o_EARLY),
        .o_TIMEOUT(o_TIMEOUT),
        .o_STATE(o_STATE)
    );

    always #5 i_CLK = ~i_CLK;
    always @(posedge i_CLK) cyc <= cyc + 1;

    assign cur = {o_STATE, o_STIM_LED, o_TIME_MS, o_VALID, o_EARLY, o_TIMEOUT};

    function automatic out_t mk(input logic [2:0] st, input logic led, input logic [13:0] tm,
                                input logic v, input logic e, input logic t);
        return {st, led, tm, v, e, t};
    endfunction

    function automatic logic [15:0] adv(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // LFSR contents seen by the edge numbered e, counting steps since the last reset edge
    function automatic logic [15:0] lfsr_at(input int e);
        logic [15:0] v = SEED;
        for (int i = 0; i < e - rst_edge - 1; i++) v = adv(v);
        return v;
    endfunction

    always @(negedge i_CLK) begin
        if (mon_en && cur != prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got st=%0d led=%0d tm=%0d v=%0d e=%0d t=%0d",
                         cyc, cur.st, cur.led, cur.tm, cur.valid, cur.early, cur.tmo);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.o != cur) begin
                    errors++;
                    $display("FAIL event got cyc=%0d st=%0d led=%0d tm=%0d v=%0d e=%0d t=%0d want cyc=%0d st=%0d led=%0d tm=%0d v=%0d e=%0d t=%0d",
                             cyc, cur.st, cur.led, cur.tm, cur.valid, cur.early, cur.tmo,
                             mon_e.cyc, mon_e.o.st, mon_e.o.led, mon_e.o.tm, mon_e.o.valid, mon_e.o.early, mon_e.o.tmo);
                end
            end
            prev = cur;
        end
    end

    task automatic push(input int e, input out_t o);
        exp_q.push_back({e, o});
    endtask

    task automatic step();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic pulse(input bit st, input bit sp, input bit cl, output int e);
        e = cyc + 1;
        i_START_TICK = st;
        i_STOP_TICK  = sp;
        i_CLEAR_TICK = cl;
        step();
        i_START_TICK = 1'b0;
        i_STOP_TICK  = 1'b0;
        i_CLEAR_TICK = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target - 1) step();
    endtask

    task automatic start_run(output int l);
        int s;
        int d;
        pulse(1'b1, 1'b0, 1'b0, s);
        d = MIN_D + int'(lfsr_at(s) & 16'h3);
        push(s, mk(3'd1, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0));
        l = s + CPM * d;
    endtask

    task automatic clear_to_idle();
        int e;
        pulse(1'b0, 1'b0, 1'b1, e);
        push(e, idle_o);
        repeat (3) step();
    endtask

    // s = cycles from LED rise to the stop press; 0 means no press (timeout)
    task automatic run_measure(input int s);
        int l;
        int e;
        start_run(l);
        push(l, mk(3'd2, 1'b1, 14'd0, 1'b0, 1'b0, 1'b0));
        if (s > 0 && s <= CPM * MAXMS) begin
            wait_until(l + s);
            pulse(1'b0, 1'b1, 1'b0, e);
            push(e, mk(3'd3, 1'b0, 14'((s - 1) / CPM), 1'b1, 1'b0, 1'b0));
        end else begin
            push(l + CPM * MAXMS, mk(3'd3, 1'b0, 14'(MAXMS), 1'b1, 1'b0, 1'b1));
            wait_until(l + CPM * MAXMS + 5);
        end
        repeat (5) step();
        pulse(1'b1, 1'b1, 1'b0, e);
        repeat (10) step();
        clear_to_idle();
    endtask

    initial begin
        int e;
        int l;
        logic [15:0] v;
        idle_o = mk(3'd0, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        rst_edge = cyc;
        i_RST = 1'b0;
        checks++;
        if (cur != idle_o) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=%h", cur, idle_o);
        end
        prev = cur;
        mon_en = 1'b1;

        v = SEED;
        for (int i = 0; i < 50; i++) begin
            step();
            v = adv(v);
            checks++;
            if (dut.lfsr != v || dut.lfsr == 16'h0) begin
                errors++;
                $display("FAIL lfsr_seq cyc=%0d got=%h want=%h", cyc, dut.lfsr, v);
            end
        end

        run_measure(29);
        run_measure(0);
        run_measure(CPM * MAXMS);
        run_measure(1);
        for (int i = 0; i < 3; i++) run_measure(int'($urandom_range(2, CPM * MAXMS - 1)));

        start_run(l);
        wait_until(cyc + 5);
        pulse(1'b0, 1'b1, 1'b0, e);
        push(e, mk(3'd4, 1'b0, 14'd0, 1'b0, 1'b1, 1'b0));
        pulse(1'b1, 1'b1, 1'b0, e);
        repeat (40) step();
        clear_to_idle();

        start_run(l);
        wait_until(l);
        pulse(1'b0, 1'b1, 1'b0, e);
        push(e, mk(3'd4, 1'b0, 14'd0, 1'b0, 1'b1, 1'b0));
        repeat (5) step();
        clear_to_idle();

        start_run(l);
        push(l, mk(3'd2, 1'b1, 14'd0, 1'b0, 1'b0, 1'b0));
        wait_until(l + 9);
        pulse(1'b0, 1'b1, 1'b1, e);
        push(e, idle_o);
        repeat (5) step();

        start_run(l);
        repeat (3) step();
        clear_to_idle();
        pulse(1'b0, 1'b0, 1'b1, e);
        repeat (5) step();

        start_run(l);
        push(l, mk(3'd2, 1'b1, 14'd0, 1'b0, 1'b0, 1'b0));
        wait_until(l + 10);
        e = cyc + 1;
        i_RST = 1'b1;
        step();
        rst_edge = cyc;
        i_RST = 1'b0;
        push(e, idle_o);
        checks++;
        if (dut.lfsr != SEED) begin
            errors++;
            $display("FAIL lfsr_after_reset got=%h want=%h", dut.lfsr, SEED);
        end
        repeat (5) step();

        run_measure(int'($urandom_range(2, CPM * MAXMS - 1)));

        repeat (5) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got=%0d want=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reaction_timer_ctrl.md
Name: reaction_timer_ctrl

Overview:
Control FSMD for the reaction-timer demo. It sits directly downstream of the push-button debouncers and consumes their single-cycle debounced ticks: start, stop and clear. It waits a pseudo-random delay, lights the stimulus LED, then measures the reaction time in milliseconds. The result goes to the display formatter as a binary millisecond count with status flags.

Parameters:
- CLK_PER_MS, 100000, clock cycles per millisecond (100 MHz clock).
- MIN_DELAY_MS, 2000, minimum random wait in ms.
- DELAY_BITS, 12, number of LFSR bits added to MIN_DELAY_MS (random span 0..2^DELAY_BITS-1 ms).
- MAX_MS, 9999, reaction timeout and saturation value in ms.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- i_CLK, input, 1, system clock.
- i_RST, input, 1, synchronous active-high reset.
- i_START_TICK, input, 1, debounced start press, one-cycle pulse.
- i_STOP_TICK, input, 1, debounced reaction press, one-cycle pulse.
- i_CLEAR_TICK, input, 1, debounced clear press, one-cycle pulse.
- o_STIM_LED, output, 1, stimulus LED, high only in MEASURE.
- o_TIME_MS, output, 14, measured reaction time in ms.
- o_VALID, output, 1, high while a completed result is held (DONE).
- o_EARLY, output, 1, high while in EARLY (stop pressed before stimulus).
- o_TIMEOUT, output, 1, high in DONE when the measurement hit MAX_MS.
- o_STATE, output, 3, current state code for debug and display.

Behaviour:
- Clocking and reset:
  - Single clock. All state and outputs are registered.
  - i_RST is sampled on the rising i_CLK edge. On reset: state=IDLE; all outputs 0; prescaler and ms counters 0; LFSR=LFSR_SEED.
- LFSR:
  - 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1.
  - Advances every cycle in every state, and never reaches zero.
- Prescaler:
  - Counts 0..CLK_PER_MS-1, then wraps to 0. ms_tick is asserted in the cycle the count equals CLK_PER_MS-1.
  - Cleared to 0 on entry to WAIT_RAND and on entry to MEASURE.
- States (o_STATE code):
  - IDLE (0): all outputs low. i_START_TICK latches delay_ms = MIN_DELAY_MS + lfsr[DELAY_BITS-1:0], using the LFSR value in the tick cycle. It also clears elapsed_ms and moves to WAIT_RAND.
  - WAIT_RAND (1): elapsed_ms increments on each ms_tick.
    - When ms_tick occurs and elapsed_ms+1 == delay_ms: go to MEASURE, reaction_ms=0, and o_STIM_LED=1 from the next cycle.
    - i_STOP_TICK: go to EARLY with o_EARLY=1 and o_TIME_MS=0.
  - MEASURE (2): o_STIM_LED=1; reaction_ms increments on each ms_tick.
    - i_STOP_TICK: go to DONE with o_TIME_MS=reaction_ms as it is in that cycle (not including a coincident ms_tick), o_VALID=1, o_STIM_LED=0.
    - When ms_tick occurs and reaction_ms+1 == MAX_MS: go to DONE with o_TIME_MS=MAX_MS, o_TIMEOUT=1, o_VALID=1.
  - DONE (3): holds o_TIME_MS, o_VALID and o_TIMEOUT. i_START_TICK and i_STOP_TICK are ignored.
  - EARLY (4): holds o_EARLY=1. i_START_TICK and i_STOP_TICK are ignored.
- Clear:
  - i_CLEAR_TICK in any state gives IDLE on the next cycle, with all outputs 0 and counters 0. The LFSR is not reset.
- Simultaneous events, priority: reset > clear > stop > timeout/delay-expiry > start.
  - Example: stop coinciding with delay expiry in WAIT_RAND gives EARLY.
- Widths:
  - elapsed_ms and reaction_ms are 14-bit.
  - Delay sum width is max(14, DELAY_BITS+1). MIN_DELAY_MS + 2^DELAY_BITS - 1 must not exceed 16383 (elaboration assertion).
- Unused state codes 5–7 recover to IDLE on the next cycle.
- Reset mid-operation aborts immediately; the LED drops on the next edge.

Test Plan:
All scenarios use CLK_PER_MS=4, MIN_DELAY_MS=3, DELAY_BITS=2, MAX_MS=20.

1. Reset, then idle 50 cycles -> o_STATE=0, all outputs 0. The LFSR sequence from 16'hACE1 matches the model, with no zero value.
2. Start tick -> o_STATE=1. o_STIM_LED rises exactly 4*delay_ms cycles after the tick, where delay_ms = 3 + model lfsr[1:0] ∈ {3..6}. Stop 4*7+1 cycles after LED rise -> o_TIME_MS=7, o_VALID=1, LED=0.
3. Start, then stop 5 cycles later -> o_STATE=4, o_EARLY=1, o_TIME_MS=0, LED never rises. A further start is ignored; clear -> IDLE.
4. Start, no stop -> 80 cycles after LED rise: o_TIME_MS=20, o_TIMEOUT=1, o_VALID=1, LED=0.
5. Stop and clear in the same cycle during MEASURE -> IDLE, o_VALID=0. Stop coinciding with the delay-expiry ms_tick -> EARLY.
6. i_RST asserted mid-MEASURE -> next edge: o_STATE=0, LED=0, o_TIME_MS=0. The LFSR returns to 16'hACE1.
